// File: rtl/freq_meter_ctrl.sv
// Frequency-meter sequencer: gated edge counting of the divider output with
// auto-ranging between pass-through and divided paths.
`timescale 1ns/1ps
module freq_meter_ctrl #(
  parameter int GATE_CYCLES   = 1000,
  parameter int CNT_W         = 12,
  parameter int HIGH_TH       = 4000,
  parameter int LOW_TH        = 300,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic             range,
  output logic [CNT_W-1:0] count,
  output logic             count_range,
  output logic             valid,
  output logic             overflow
);

  localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0]  GATE_LAST   = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0]  SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W:0] HIGH_C      = (CNT_W+1)'(HIGH_TH);
  localparam logic [CNT_W:0] LOW_C       = (CNT_W+1)'(LOW_TH);

  typedef enum logic [1:0] {IDLE, MEASURE, DECIDE, SETTLE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sync_q;
  logic             edge_pulse;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             range_q, range_d;
  logic             crange_q, crange_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             sw_up, sw_dn, publish;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Two synchronizer flops plus one history flop; sig_in data path needs no reset
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[1:0], sig_in};
  end

  assign edge_pulse = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = MEASURE;
      MEASURE: if (!en) state_d = IDLE;
               else if (tmr_q == GATE_LAST) state_d = DECIDE;
      DECIDE:  if (!en) state_d = IDLE;
               else if (sw_up || sw_dn) state_d = SETTLE;
               else state_d = MEASURE;
      SETTLE:  if (!en) state_d = IDLE;
               else if (tmr_q == SETTLE_LAST) state_d = MEASURE;
      default: state_d = IDLE;
    endcase
  end

  // The decision is complete in DECIDE, so it still takes effect if en falls there
  always_comb begin
    sw_up   = (state_q == DECIDE) && !range_q && ({1'b0, cnt_q} >= HIGH_C);
    sw_dn   = (state_q == DECIDE) &&  range_q && ({1'b0, cnt_q} <  LOW_C);
    publish = (state_q == DECIDE) && !sw_up && !sw_dn;
  end

  always_comb begin
    tmr_d = '0;
    if ((state_q == MEASURE || state_q == SETTLE) && state_d == state_q)
      tmr_d = tmr_q + TW'(1);
    cnt_d = '0;
    if (state_q == MEASURE && en)
      cnt_d = edge_pulse ? sat_inc(cnt_q) : cnt_q;
    range_d  = range_q;
    if (sw_up) range_d = 1'b1;
    if (sw_dn) range_d = 1'b0;
    count_d  = publish ? cnt_q : count_q;
    crange_d = publish ? range_q : crange_q;
    ovf_d    = publish ? ((&cnt_q) & range_q) : ovf_q;
    valid_d  = publish;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr_q    <= '0;
      cnt_q    <= '0;
      count_q  <= '0;
      range_q  <= 1'b0;
      crange_q <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      tmr_q    <= tmr_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      range_q  <= range_d;
      crange_q <= crange_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign range       = range_q;
  assign count       = count_q;
  assign count_range = crange_q;
  assign valid       = valid_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Directed bench for freq_meter_ctrl: a divider model feeds sig_in and a
// scoreboard queue holds the expected published results.
`timescale 1ns/1ps
module tb_freq_meter_ctrl;
  localparam int G = 100, CW = 8, HT = 40, LT = 3, ST = 4;

  logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, sig_in = 1'b0;
  logic          range, count_range, valid, overflow;
  logic [CW-1:0] count;

  // Second instance with a narrow counter, so saturation and overflow are reachable
  logic          en_b = 1'b0, sig_b = 1'b0;
  logic          range_b, crange_b, valid_b, ovf_b;
  logic [3:0]    count_b;

  int errors = 0, checks = 0;
  int base_p = 10;
  int ph = 0;

  typedef struct packed { logic [CW-1:0] c; logic r; logic o; } res_t;
  res_t exp_q[$];

  always #5 clk = ~clk;

  freq_meter_ctrl #(.GATE_CYCLES(G), .CNT_W(CW), .HIGH_TH(HT), .LOW_TH(LT),
                    .SETTLE_CYCLES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .range(range),
    .count(count), .count_range(count_range), .valid(valid), .overflow(overflow));

  freq_meter_ctrl #(.GATE_CYCLES(40), .CNT_W(4), .HIGH_TH(8), .LOW_TH(1),
                    .SETTLE_CYCLES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .sig_in(sig_b), .range(range_b),
    .count(count_b), .count_range(crange_b), .valid(valid_b), .overflow(ovf_b));

  function automatic int cur_per();
    return range ? base_p * 10 : base_p;
  endfunction

  // Divider model: base period in pass-through, ten times longer when range=1
  always @(negedge clk) begin
    if (ph >= cur_per() - 1) ph <= 0;
    else                     ph <= ph + 1;
    sig_in <= (ph < cur_per() / 2);
    sig_b  <= ~sig_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      @(posedge clk); #1; n++;
      if (valid) break;
    end
  endtask

  task automatic wait_range(input logic val, input int maxc, output int n, output int nv);
    n = 0; nv = 0;
    while (n < maxc) begin
      @(posedge clk); #1; n++;
      if (valid) nv++;
      if (range === val) break;
    end
  endtask

  task automatic count_valids(input int cyc, output int nv);
    nv = 0;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk); #1;
      if (valid) nv++;
    end
  endtask

  task automatic push(input int c, input logic r, input logic o);
    res_t e;
    e.c = CW'(c); e.r = r; e.o = o;
    exp_q.push_back(e);
  endtask

  // Scoreboard consumer
  initial begin
    res_t e;
    logic valid_prev;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (valid) begin
        chk("valid_single_cycle", valid_prev, 0);
        chk("valid_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("count", count, e.c);
          chk("count_range", count_range, e.r);
          chk("overflow", overflow, e.o);
        end
      end
      valid_prev = valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, nv;
    // Reset held with en high
    en = 1'b1; rst_n = 1'b0; base_p = 10;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_range", range, 0);
    chk("rst_count", count, 0);
    chk("rst_count_range", count_range, 0);
    chk("rst_valid", valid, 0);
    chk("rst_overflow", overflow, 0);

    // Startup latency and steady range-0 results
    push(10, 0, 0); push(10, 0, 0); push(10, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    wait_valid(300, n);
    chk("first_valid_cycle", n + 1, G + 3);
    wait_valid(300, n);
    chk("valid_period_1", n, G + 1);
    wait_valid(300, n);
    chk("valid_period_2", n, G + 1);

    // Up-range: 50 edges discarded, then divided input gives 5
    en = 1'b0; base_p = 2;
    repeat (10) @(posedge clk);
    push(5, 1, 0);
    @(negedge clk); en = 1'b1;
    wait_range(1'b1, 300, n, nv);
    chk("upswitch_cycle", n, G + 2);
    chk("upswitch_no_valid", nv, 0);
    wait_valid(300, n);
    chk("switch_to_valid", n, ST + G + 1);
    chk("range_held_1", range, 1);

    // Down-range: divided period 50 gives 2 edges, then pass-through gives 20
    en = 1'b0; base_p = 5;
    repeat (10) @(posedge clk);
    push(20, 0, 0);
    @(negedge clk); en = 1'b1;
    wait_range(1'b0, 300, n, nv);
    chk("downswitch_cycle", n, G + 2);
    chk("downswitch_no_valid", nv, 0);
    wait_valid(300, n);
    chk("down_to_valid", n, ST + G + 1);

    // Enable abort at window cycle 50, then a fresh window
    en = 1'b0; base_p = 10;
    repeat (10) @(posedge clk);
    @(negedge clk); en = 1'b1;
    repeat (51) @(posedge clk);
    @(negedge clk); en = 1'b0;
    count_valids(200, nv);
    chk("abort_no_valid", nv, 0);
    chk("abort_range_held", range, 0);
    chk("abort_count_held", count, 20);
    chk("abort_count_range_held", count_range, 0);
    push(10, 0, 0);
    @(negedge clk); en = 1'b1;
    wait_valid(300, n);
    chk("restart_latency", n, G + 2);

    // Reset during SETTLE after an up-range
    en = 1'b0; base_p = 2;
    repeat (10) @(posedge clk);
    @(negedge clk); en = 1'b1;
    wait_range(1'b1, 300, n, nv);
    chk("upswitch2_cycle", n, G + 2);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_range", range, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_count", count, 0);
    chk("midrst_overflow", overflow, 0);
    @(negedge clk); rst_n = 1'b1;
    wait_range(1'b1, 300, n, nv);
    chk("post_rst_upswitch_cycle", n, G + 2);
    chk("post_rst_no_valid", nv, 0);
    en = 1'b0;

    // Narrow instance: range-0 saturation switches up, range-1 saturation flags overflow
    @(negedge clk); en_b = 1'b1;
    n = 0;
    while (n < 400) begin
      @(posedge clk); #1; n++;
      if (valid_b) break;
    end
    chk("b_valid_cycle", n, 85);
    chk("b_count_sat", count_b, 15);
    chk("b_count_range", crange_b, 1);
    chk("b_overflow", ovf_b, 1);
    chk("b_range", range_b, 1);
    en_b = 1'b0;

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
